tile_hp_map: RTL

Parametrised playfield tile map holding a per-tile hit-point value for a ROWS×COLS grid of 2^TILE_LOG2-pixel square tiles. It renders the tile under the current VGA pixel with a one-cycle registered draw request and offsets, and applies damage from HIT_CH independent collision channels. It reloads the whole map from an external level ROM through a sequential load engine. It sits between the collision logic and the VGA object mux, replacing the fixed single-channel brick matrix.

---
 rtl/tile_hp_map.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tile_hp_map.sv
// Playfield tile map: per-tile hit points, registered VGA draw path, multi-channel damage
// and a sequential level-ROM load engine. Define TILE_MAP_STEEL_EN for indestructible tiles.
`timescale 1ns / 1ps

module tile_hp_map #(
  parameter int unsigned COLS         = 17,
  parameter int unsigned ROWS         = 14,
  parameter int unsigned TILE_LOG2    = 5,
  parameter int unsigned HP_W         = 3,
  parameter int unsigned HIT_CH       = 2,
  parameter logic [7:0]  OBJECT_COLOR = 8'h5b
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [10:0]            pixelX,
  input  logic [10:0]            pixelY,
  input  logic [10:0]            topLeftX,
  input  logic [10:0]            topLeftY,
  input  logic [HIT_CH-1:0]      hitValid,
  input  logic [HIT_CH*5-1:0]    hitCol,
  input  logic [HIT_CH*4-1:0]    hitRow,
  input  logic                   loadStart,
  output logic [8:0]             romAddr,
  input  logic [HP_W-1:0]        romData,
  output logic                   busy,
  output logic [10:0]            offsetX,
  output logic [10:0]            offsetY,
  output logic                   drawingRequest,
  output logic [7:0]             RGBout,
  output logic [HP_W-1:0]        tileHp,
  output logic [ROWS*COLS-1:0]   occupancy,
  output logic [HIT_CH-1:0]      destroyed,
  output logic [8:0]             tilesLeft
);

  localparam int          NumTiles = ROWS * COLS;
  localparam logic [9:0]  LastAddr = 10'(NumTiles);
  localparam logic [10:0] TileMask = 11'((1 << TILE_LOG2) - 1);
  localparam logic [HP_W-1:0] HpOne = HP_W'(1);

`ifdef TILE_MAP_STEEL_EN
  localparam bit SteelEn = 1'b1;
`else
  localparam bit SteelEn = 1'b0;
`endif

  function automatic logic is_steel(input logic [HP_W-1:0] hp);
    return SteelEn && (&hp);
  endfunction

  // ---------------------------------------------------------------------------
  // Load engine FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {StIdle, StLoad} state_e;

  state_e     state_q, state_d;
  logic [9:0] addr_q;
  logic [9:0] wr_idx;
  logic       load_go, load_wr, load_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (loadStart) state_d = StLoad;
      StLoad:  if (load_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    load_go   = 1'b0;
    load_wr   = 1'b0;
    load_last = 1'b0;
    case (state_q)
      StIdle: load_go = loadStart;
      StLoad: begin
        busy      = 1'b1;
        // ROM data lags the address by one cycle, so the write trails the counter.
        load_wr   = (addr_q != 10'd0);
        load_last = (addr_q == LastAddr);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= 10'd0;
    end else if (load_go || load_last) begin
      addr_q <= 10'd0;
    end else if (busy) begin
      addr_q <= addr_q + 10'd1;
    end
  end

  assign romAddr = addr_q[8:0];
  assign wr_idx  = addr_q - 10'd1;

  // ---------------------------------------------------------------------------
  // Tile storage
  // ---------------------------------------------------------------------------
  logic [HP_W-1:0] hp_q [NumTiles];
  logic [HP_W-1:0] hp_d [NumTiles];

  always_comb begin
    for (int i = 0; i < NumTiles; i++) begin
      occupancy[i] = (hp_q[i] != '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Draw path
  // ---------------------------------------------------------------------------
  logic [11:0]     dx, dy;
  logic [10:0]     px_col, px_row;
  logic            in_map;
  logic [9:0]      px_idx;
  logic [HP_W-1:0] px_hp;

  always_comb begin
    dx     = {1'b0, pixelX} - {1'b0, topLeftX};
    dy     = {1'b0, pixelY} - {1'b0, topLeftY};
    px_col = dx[10:0] >> TILE_LOG2;
    px_row = dy[10:0] >> TILE_LOG2;
    in_map = !dx[11] && !dy[11] && (32'(px_col) < COLS) && (32'(px_row) < ROWS);
    px_idx = 10'(32'(px_row) * COLS + 32'(px_col));
    px_hp  = '0;
    for (int i = 0; i < NumTiles; i++) begin
      if (in_map && (px_idx == 10'(i))) px_hp = hp_q[i];
    end
  end

  assign tileHp = px_hp;

  always_ff @(posedge clk) begin
    if (reset) begin
      drawingRequest <= 1'b0;
      RGBout         <= 8'hFF;
      offsetX        <= 11'd0;
      offsetY        <= 11'd0;
    end else begin
      drawingRequest <= in_map && (px_hp != '0);
      RGBout         <= (in_map && (px_hp != '0)) ? OBJECT_COLOR : 8'hFF;
      offsetX        <= in_map ? (dx[10:0] & TileMask) : 11'd0;
      offsetY        <= in_map ? (dy[10:0] & TileMask) : 11'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Hit channels
  // ---------------------------------------------------------------------------
  logic [HIT_CH-1:0] hit_prev_q, hit_rise, hit_in_grid, hit_ok, hit_win, hit_kill;
  logic [4:0]        hit_col [HIT_CH];
  logic [3:0]        hit_row [HIT_CH];
  logic [9:0]        hit_idx [HIT_CH];
  logic [HP_W-1:0]   hit_hp  [HIT_CH];
  logic [8:0]        kill_cnt;

  always_comb begin
    hit_rise = hitValid & ~hit_prev_q;
    for (int c = 0; c < HIT_CH; c++) begin
      hit_col[c]     = hitCol[c*5 +: 5];
      hit_row[c]     = hitRow[c*4 +: 4];
      hit_in_grid[c] = (32'(hit_col[c]) < COLS) && (32'(hit_row[c]) < ROWS);
      hit_idx[c]     = 10'(32'(hit_row[c]) * COLS + 32'(hit_col[c]));
      hit_hp[c]      = '0;
      for (int i = 0; i < NumTiles; i++) begin
        if (hit_in_grid[c] && (hit_idx[c] == 10'(i))) hit_hp[c] = hp_q[i];
      end
      hit_ok[c] = hit_rise[c] && !busy && hit_in_grid[c] && (hit_hp[c] != '0) &&
                  !is_steel(hit_hp[c]);
    end
    // Several channels on one tile: only the lowest-index channel lands its hit.
    hit_win = hit_ok;
    for (int c = 1; c < HIT_CH; c++) begin
      for (int j = 0; j < c; j++) begin
        if (hit_ok[j] && (hit_idx[j] == hit_idx[c])) hit_win[c] = 1'b0;
      end
    end
    kill_cnt = 9'd0;
    for (int c = 0; c < HIT_CH; c++) begin
      hit_kill[c] = hit_win[c] && (hit_hp[c] == HpOne);
      kill_cnt    = kill_cnt + 9'(hit_kill[c]);
    end
  end

  always_comb begin
    for (int i = 0; i < NumTiles; i++) begin
      hp_d[i] = hp_q[i];
      if (load_wr && (wr_idx == 10'(i))) hp_d[i] = romData;
      for (int c = 0; c < HIT_CH; c++) begin
        if (hit_win[c] && (hit_idx[c] == 10'(i))) hp_d[i] = hp_q[i] - HpOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NumTiles; i++) hp_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumTiles; i++) hp_q[i] <= hp_d[i];
    end
  end

  // Edge flags keep following the level during a load so a held hit never fires afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_prev_q <= '0;
      destroyed  <= '0;
    end else begin
      hit_prev_q <= hitValid;
      destroyed  <= hit_kill;
    end
  end

  logic load_count;
  assign load_count = load_wr && (romData != '0) && !is_steel(romData);

  always_ff @(posedge clk) begin
    if (reset) begin
      tilesLeft <= 9'd0;
    end else if (load_go) begin
      tilesLeft <= 9'd0;
    end else if (load_count) begin
      tilesLeft <= tilesLeft + 9'd1;
    end else begin
      tilesLeft <= tilesLeft - kill_cnt;
    end
  end

endmodule
